// File: rtl/pe_inst_seq.sv
// Instruction sequencer for the PE data memory: buffers a short microprogram and
// replays it loop_num times, with write-back enables delayed to line up with results.
module pe_inst_seq #(
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int PTR_W      = 4,
  parameter int LOOP_W     = 8,
  parameter int WB_LAT     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_in_v,
  input  logic [INST_WIDTH-1:0] inst_in,
  output logic                  inst_in_rdy,
  input  logic                  clear,
  input  logic                  start,
  input  logic [LOOP_W-1:0]     loop_num,
  output logic                  inst_v,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  rden,
  output logic                  wben,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [PTR_W:0]    DEPTH_C  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]  PC_ONE   = PTR_W'(1);
  localparam logic [LOOP_W-1:0] LOOP_ONE = LOOP_W'(1);

  // A zero iteration request still runs the program once.
  function automatic logic [LOOP_W-1:0] sat_loops(input logic [LOOP_W-1:0] n);
    return (n == '0) ? LOOP_ONE : n;
  endfunction

  state_t                state, state_nx;
  logic [INST_WIDTH-1:0] prog_mem [DEPTH];
  logic [PTR_W:0]        count, count_nx;
  logic [PTR_W-1:0]      pc, pc_nx;
  logic [LOOP_W-1:0]     iter, iter_nx, loops, loops_nx;
  logic [WB_LAT:0]       wb_pipe;
  logic                  load_ok, start_ok, pc_last, last_issue;
  logic [INST_WIDTH-1:0] cur_inst, inst_d;
  logic                  inst_v_d, rden_d, wb_d, busy_d, done_d, rdy_d;

  assign cur_inst   = prog_mem[pc];
  assign load_ok    = (state == IDLE) && inst_in_v && !clear && (count < DEPTH_C);
  assign pc_last    = ({1'b0, pc} == (count - CNT_ONE));
  assign last_issue = (state == RUN) && pc_last && (iter == (loops - LOOP_ONE));
  // wb_pipe[0] sits alongside inst_v, so tap WB_LAT is exactly WB_LAT cycles later.
  assign wben       = wb_pipe[WB_LAT];

  // Buffer contents, count, loop bookkeeping
  always_comb begin
    count_nx = count;
    if (state == IDLE) begin
      if (clear)
        count_nx = '0;
      else if (load_ok)
        count_nx = count + CNT_ONE;
    end
    start_ok = (state == IDLE) && start && (count_nx != '0);

    pc_nx    = pc;
    iter_nx  = iter;
    loops_nx = loops;
    if (start_ok) begin
      loops_nx = sat_loops(loop_num);
      pc_nx    = '0;
      iter_nx  = '0;
    end else if (state == RUN) begin
      if (pc_last) begin
        pc_nx   = '0;
        iter_nx = iter + LOOP_ONE;
      end else begin
        pc_nx = pc + PC_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_ok)
      prog_mem[count[PTR_W-1:0]] <= inst_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      pc    <= '0;
      iter  <= '0;
      loops <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      pc    <= pc_nx;
      iter  <= iter_nx;
      loops <= loops_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = RUN;
      RUN:     if (last_issue) state_nx = DRAIN;
      DRAIN:   if (wb_pipe[WB_LAT-1:0] == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    inst_v_d = 1'b0;
    rden_d   = 1'b0;
    wb_d     = 1'b0;
    inst_d   = inst;
    if (state == RUN) begin
      inst_v_d = 1'b1;
      inst_d   = cur_inst;
      rden_d   = (cur_inst[INST_WIDTH-1 -: 8] != 8'h00);
      wb_d     = cur_inst[INST_WIDTH-1];
    end
    busy_d = (state_nx != IDLE);
    done_d = (state == DRAIN) && (state_nx == IDLE);
    rdy_d  = (state_nx == IDLE) && (count_nx < DEPTH_C);
  end

  // Issue stage -> memory interface registers
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_v      <= 1'b0;
      inst        <= '0;
      rden        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      inst_in_rdy <= 1'b0;
      wb_pipe     <= '0;
    end else begin
      inst_v      <= inst_v_d;
      inst        <= inst_d;
      rden        <= rden_d;
      busy        <= busy_d;
      done        <= done_d;
      inst_in_rdy <= rdy_d;
      wb_pipe     <= {wb_pipe[WB_LAT-1:0], wb_d};
    end
  end

endmodule
